// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver: the blank pattern and
// the active-low hex glyph table ({g,f,e,d,c,b,a}, bit0 = a).
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low 7-segment glyph.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed 7-segment scanner with frame-coherent input capture,
// leading-zero suppression and a per-slot blanking gap.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic [4*NUM_DIGITS-1:0] digit_val_i,
  input  logic [7*NUM_DIGITS-1:0] raw_seg_i,
  input  logic [NUM_DIGITS-1:0]   raw_mode_i,
  input  logic [NUM_DIGITS-1:0]   dp_in_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    lz_suppress_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_tick_o
);

  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  // Shadow copy of the inputs, reloaded once per frame.
  logic [NUM_DIGITS-1:0][3:0] sh_val_q;
  logic [NUM_DIGITS-1:0][6:0] sh_raw_q;
  logic [NUM_DIGITS-1:0]      sh_mode_q;
  logic [NUM_DIGITS-1:0]      sh_dp_q;
  logic [NUM_DIGITS-1:0]      sh_den_q;
  logic                       sh_lz_q;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic                  tick_q;

  logic                  capture;
  logic [NUM_DIGITS-1:0] supp;
  logic [6:0]            hex_seg;

  assign capture = en_i && (cnt_q == '0) && (slot_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (!en_i) begin
      cnt_d  = '0;
      slot_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Walk from the most significant digit down; suppression continues only while
  // every digit above is disabled or itself suppressed.
  always_comb begin
    logic clear;
    supp  = '0;
    clear = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      supp[i] = sh_lz_q && !sh_mode_q[i] && (sh_val_q[i] == 4'h0) && clear;
      clear   = clear && (!sh_den_q[i] || supp[i]);
    end
  end

  seg_hex_decoder u_hex (
    .nibble_i (sh_val_q[slot_q]),
    .seg_o    (hex_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dpo_d = 1'b1;
    if (en_i && (cnt_q >= CNT_BLANK) && sh_den_q[slot_q] && !supp[slot_q]) begin
      an_d  = ~(NUM_DIGITS'(1) << slot_q);
      seg_d = sh_mode_q[slot_q] ? sh_raw_q[slot_q] : hex_seg;
      dpo_d = ~sh_dp_q[slot_q];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      slot_q    <= '0;
      sh_val_q  <= '0;
      sh_raw_q  <= '0;
      sh_mode_q <= '0;
      sh_dp_q   <= '0;
      sh_den_q  <= '0;
      sh_lz_q   <= 1'b0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      dpo_q     <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dpo_q  <= dpo_d;
      tick_q <= capture;
      // Capture lands on a blanked cycle, so the display never sees a half-loaded frame.
      if (capture) begin
        sh_val_q  <= digit_val_i;
        sh_raw_q  <= raw_seg_i;
        sh_mode_q <= raw_mode_i;
        sh_dp_q   <= dp_in_i;
        sh_den_q  <= digit_en_i;
        sh_lz_q   <= lz_suppress_i;
      end
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dpo_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: a cycle-position reference model pushes expected outputs at
// each rising edge; a monitor pops and compares them on the falling edge.
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         ft;
  } obs_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [4*N-1:0] digit_val = '0;
  logic [7*N-1:0] raw_seg = '0;
  logic [N-1:0]   raw_mode = '0;
  logic [N-1:0]   dp_in = '0;
  logic [N-1:0]   digit_en = '0;
  logic           lz = 1'b0;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   an;
  logic           frame_tick;

  int checks = 0;
  int errors = 0;
  obs_t expq[$];

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .en_i          (en),
    .digit_val_i   (digit_val),
    .raw_seg_i     (raw_seg),
    .raw_mode_i    (raw_mode),
    .dp_in_i       (dp_in),
    .digit_en_i    (digit_en),
    .lz_suppress_i (lz),
    .seg_o         (seg),
    .dp_o          (dp),
    .an_o          (an),
    .frame_tick_o  (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: p = enabled cycles since the scan (re)started.
  initial begin
    int p;
    logic [4*N-1:0] m_val;
    logic [7*N-1:0] m_raw;
    logic [N-1:0]   m_mode, m_dp, m_den;
    logic           m_lz;
    bit             sup [N];
    bit             lead;
    int             sl, c;
    obs_t           e;
    p = 0;
    m_val = '0; m_raw = '0; m_mode = '0; m_dp = '0; m_den = '0; m_lz = 1'b0;
    forever begin
      @(posedge clk);
      e = '{an: '1, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
      if (rst) begin
        p = 0;
        m_val = '0; m_raw = '0; m_mode = '0; m_dp = '0; m_den = '0; m_lz = 1'b0;
      end else if (!en) begin
        p = 0;
      end else begin
        if (p % FRAME == 0) begin
          m_val = digit_val; m_raw = raw_seg; m_mode = raw_mode;
          m_dp = dp_in; m_den = digit_en; m_lz = lz;
          e.ft = 1'b1;
        end
        lead = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
          sup[i] = m_lz && !m_mode[i] && (m_val[i*4 +: 4] == 4'h0) && (i > 0) && lead;
          if (m_den[i] && !sup[i]) lead = 1'b0;
        end
        sl = (p / DIV) % N;
        c  = p % DIV;
        if (c >= BLANK && m_den[sl] && !sup[sl]) begin
          e.an  = ~(N'(1) << sl);
          e.seg = m_mode[sl] ? m_raw[sl*7 +: 7] : hex_tab[m_val[sl*4 +: 4]];
          e.dp  = ~m_dp[sl];
        end
        p++;
      end
      expq.push_back(e);
    end
  end

  // Monitor: one comparison per cycle, sampled away from the active edge.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      a = '{an: an, seg: seg, dp: dp, ft: frame_tick};
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got an=%b seg=%h dp=%b ft=%b want an expected entry",
                 $time, a.an, a.seg, a.dp, a.ft);
      end else begin
        e = expq.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                   $time, a.an, a.seg, a.dp, a.ft, e.an, e.seg, e.dp, e.ft);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [4*N-1:0] rand_val();
    logic [4*N-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got no end of stimulus want completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for three edges.
    cyc(3);
    rst = 1'b0;
    // Decoded digits with leading-zero suppression, then without.
    digit_val = 16'h0407; digit_en = 4'hF; lz = 1'b1; en = 1'b1;
    cyc(40);
    lz = 1'b0;
    cyc(32);
    // Mid-frame change must not show until the next frame.
    cyc(10);
    digit_val = 16'hFFFF;
    cyc(60);
    // Raw top digit blocks suppression below it.
    raw_mode = 4'b1000; raw_seg = '0; raw_seg[27:21] = 7'h3F;
    digit_val = 16'h0005; dp_in = 4'b0010; lz = 1'b1;
    cyc(50);
    // Enable drop mid-slot and restart, then a reset mid-slot.
    cyc(18);
    en = 1'b0;
    cyc(5);
    en = 1'b1;
    cyc(20);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(40);
    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) digit_val = rand_val();
      if ($urandom_range(0, 63) == 0) begin
        raw_seg  = 28'($urandom);
        raw_mode = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom);
        dp_in    = N'($urandom);
        digit_en = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom);
        lz       = 1'($urandom);
      end
      if ($urandom_range(0, 199) == 0) en = ~en;
      rst = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
